md_dispatch: RTL and testbench
==============================

// Module: md_dispatch
// PURPOSE
//  E-stage issue side of the HI/LO multiply/divide unit (MDU) handshake. Decodes the E-stage
//  md-class op, drives the MDU start/write/read ports, shadows the MDU busy countdown, and
//  raises a pipeline stall while an op cannot issue. Flags any MDU busy sequence that differs
//  from the shadow count.
// PARAMETERS
//  MUL_LAT  5   busy value the MDU loads on mult/multu start
//  DIV_LAT  10  busy value the MDU loads on div/divu start
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low; all state cleared while 0
//  e_valid      in   1   E-stage instruction valid
//  md_op        in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//  rs_val       in   32  forwarded rs operand
//  rt_val       in   32  forwarded rt operand
//  md_busy      in   4   MDU busy countdown
//  md_data_out  in   32  MDU HI/LO read data
//  md_start     out  3   to MDU: 001 multu,010 mult,011 divu,100 div,000 idle
//  md_in1       out  32  to MDU operand 1 (= rs_val)
//  md_in2       out  32  to MDU operand 2 (= rt_val)
//  md_wdata     out  32  to MDU write data (= rs_val)
//  md_we        out  1   to MDU HI/LO write enable
//  md_addr      out  1   to MDU select: 1 HI, 0 LO
//  stall        out  1   hold D/E stages this cycle
//  mf_result    out  32  mfhi/mflo result for E-stage write-back mux
//  proto_err    out  1   sticky: MDU busy disagreed with the shadow count
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cnt=0, proto_err=0. All outputs are combinational
//   from state and therefore 0 during reset, including stall.
//  md_req = e_valid && md_op in 1..8. Ops 9..15 are treated as none: no stall, no MDU action.
//  stall = md_req && (cnt!=0 || md_busy!=0). This covers all md-class ops; mt/mf wait too.
//  accept = md_req && !stall. MDU outputs are non-zero only on accept; otherwise start=0, we=0.
//  On accept:
//   - mult/multu/div/divu: md_start per the encoding.
//   - mthi/mtlo: md_we=1, md_addr = (op==mthi).
//   - mfhi/mflo: md_addr = (op==mfhi), mf_result = md_data_out in the same cycle, no state change.
//  md_addr defaults to 0 when not accepting an mf/mt op.
//  FSM IDLE/BUSY, cnt is 4 bits:
//   - IDLE, accept of mult-class: cnt<=MUL_LAT, ->BUSY.
//   - IDLE, accept of div-class: cnt<=DIV_LAT, ->BUSY.
//   - BUSY: cnt<=cnt-1 each cycle; cnt==1 -> cnt<=0, ->IDLE. HI/LO are valid from the next cycle.
//  Protocol check: in BUSY, md_busy!=cnt sets proto_err (sticky until reset).
//   The stall term still ORs md_busy, so a slow MDU can never be overrun.
//  Latency: mult op to first mfhi issue is MUL_LAT+1 cycles; div op is DIV_LAT+1 cycles.
//  Back-to-back: a second mult/div in the cycle after accept stalls for the full countdown.
//  Reset mid-op: FSM returns to IDLE at once. The MDU is reset by the same system reset.
// STRUCTURE
//  Shared package md_pkg: md_op codes, MDU start encodings, MUL_LAT/DIV_LAT defaults, FSM state enum.
//  Single flat module. Decode is one always_comb; FSM, cnt and proto_err share one always_ff.
//  No sub-module.
// TESTING (bench pairs md_dispatch with a behavioural MDU model)
//  1 mult rs=0xFFFFFFFF rt=2, then mfhi next cycle:
//    start=010 for 1 cycle; stall on mfhi for 5 cycles; mf_result=0xFFFFFFFF.
//  2 divu rs=7 rt=2, then mflo, then mfhi:
//    stall 10 cycles; mflo=3 on the cycle it issues; mfhi=1 one cycle later.
//  3 mthi 0x1234 during a div:
//    stall until cnt==0; then we=1, addr=1 for 1 cycle; a following mfhi returns 0x00001234.
//  4 Model MDU loads busy=6 for mult:
//    proto_err=1 one cycle after start; stall holds until md_busy==0.
//  5 reset=0 asserted 3 cycles into a div:
//    stall=0, start=0 immediately. After release, mult accepted in its first valid cycle.
//  6 e_valid=0 with md_op=1, and e_valid=1 with md_op=12:
//    no start, no stall, state stays IDLE.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the E-stage MDU dispatch: op codes, MDU start encodings,
// default latencies and the dispatch FSM state.
package md_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8
  } md_op_e;

  typedef enum logic [2:0] {
    StartIdle  = 3'b000,
    StartMultu = 3'b001,
    StartMult  = 3'b010,
    StartDivu  = 3'b011,
    StartDiv   = 3'b100
  } md_start_e;

  localparam int unsigned MulLatDefault = 5;
  localparam int unsigned DivLatDefault = 10;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

endpackage

// File: rtl/md_if.sv
// Dispatch-to-MDU port bundle. The dispatcher is the master; the HI/LO unit is the slave.
interface md_if;
  logic [2:0]  md_start;
  logic [31:0] md_in1;
  logic [31:0] md_in2;
  logic [31:0] md_wdata;
  logic        md_we;
  logic        md_addr;
  logic [3:0]  md_busy;
  logic [31:0] md_data_out;

  modport master (
    output md_start, md_in1, md_in2, md_wdata, md_we, md_addr,
    input  md_busy, md_data_out
  );

  modport slave (
    input  md_start, md_in1, md_in2, md_wdata, md_we, md_addr,
    output md_busy, md_data_out
  );
endinterface

// File: rtl/md_dispatch.sv
// E-stage issue side of the HI/LO multiply/divide handshake: decodes md ops, drives the MDU,
// shadows its busy countdown and stalls the pipeline until an op can issue.
module md_dispatch
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned DIV_LAT = DivLatDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  md_if.master        mdu,
  output logic        stall,
  output logic [31:0] mf_result,
  output logic        proto_err
);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic md_req;
  logic busy_any;
  logic accept;
  logic is_mul;
  logic is_div;

  // Every output is forced to zero while reset is held, independent of MDU inputs.
  always_comb begin
    md_req    = e_valid && (md_op >= 4'd1) && (md_op <= 4'd8);
    busy_any  = (cnt_q != 4'd0) || (mdu.md_busy != 4'd0);
    stall     = reset && md_req && busy_any;
    accept    = reset && md_req && !busy_any;
    is_mul    = (md_op == OpMult) || (md_op == OpMultu);
    is_div    = (md_op == OpDiv) || (md_op == OpDivu);

    mdu.md_start  = StartIdle;
    mdu.md_we     = 1'b0;
    mdu.md_addr   = 1'b0;
    mdu.md_in1    = reset ? rs_val : 32'd0;
    mdu.md_in2    = reset ? rt_val : 32'd0;
    mdu.md_wdata  = reset ? rs_val : 32'd0;
    mf_result     = 32'd0;
    proto_err     = err_q;

    if (accept) begin
      case (md_op)
        OpMult:  mdu.md_start = StartMult;
        OpMultu: mdu.md_start = StartMultu;
        OpDiv:   mdu.md_start = StartDiv;
        OpDivu:  mdu.md_start = StartDivu;
        OpMfhi: begin
          mdu.md_addr = 1'b1;
          mf_result   = mdu.md_data_out;
        end
        OpMflo:  mf_result = mdu.md_data_out;
        OpMthi: begin
          mdu.md_we   = 1'b1;
          mdu.md_addr = 1'b1;
        end
        OpMtlo:  mdu.md_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mul) begin
          cnt_d   = 4'(MUL_LAT);
          state_d = StBusy;
        end else if (accept && is_div) begin
          cnt_d   = 4'(DIV_LAT);
          state_d = StBusy;
        end
      end
      StBusy: begin
        // The MDU must count down in lock-step with the shadow.
        if (mdu.md_busy != cnt_q) err_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_md_dispatch.sv
// Bench for md_dispatch: behavioural MDU model on the slave side, directed scenarios plus
// randomized traffic checked against a cycle-count reference model.
module tb_md_dispatch;
  import md_pkg::*;

  localparam int unsigned LatMul = 5;
  localparam int unsigned LatDiv = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        stall;
  logic [31:0] mf_result;
  logic        proto_err;

  md_if bus ();

  md_dispatch #(
    .MUL_LAT(LatMul),
    .DIV_LAT(LatDiv)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .mdu      (bus),
    .stall    (stall),
    .mf_result(mf_result),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // HI/LO results of an md op, op coded as on the md_op port.
  function automatic void md_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p;
    int ia, ib;
    hi = 32'd0;
    lo = 32'd0;
    if (op == 4'd1 || op == 4'd2) begin
      sa = (op == 4'd1 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
      sb = (op == 4'd1 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
      p  = sa * sb;
      {hi, lo} = p;
    end else if ((op == 4'd3 || op == 4'd4) && b != 32'd0) begin
      if (op == 4'd3) begin
        ia = a;
        ib = b;
        lo = ia / ib;
        hi = ia % ib;
      end else begin
        lo = a / b;
        hi = a % b;
      end
    end
  endfunction

  // Behavioural MDU; mdu_mul_busy lets a scenario make it misreport its multiply latency.
  int unsigned mdu_mul_busy = LatMul;
  logic [31:0] m_hi, m_lo;
  logic [3:0]  m_busy;
  logic [3:0]  m_op;
  logic [31:0] c_hi, c_lo;

  assign bus.md_busy     = m_busy;
  assign bus.md_data_out = bus.md_addr ? m_hi : m_lo;

  always_comb begin
    case (bus.md_start)
      3'b010:  m_op = 4'd1;
      3'b001:  m_op = 4'd2;
      3'b100:  m_op = 4'd3;
      3'b011:  m_op = 4'd4;
      default: m_op = 4'd0;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_busy <= 4'd0;
    end else begin
      if (m_busy != 4'd0) m_busy <= m_busy - 4'd1;
      if (m_op != 4'd0) begin
        md_calc(m_op, bus.md_in1, bus.md_in2, c_hi, c_lo);
        m_hi   <= c_hi;
        m_lo   <= c_lo;
        m_busy <= (m_op <= 4'd2) ? 4'(mdu_mul_busy) : 4'(LatDiv);
      end
      if (bus.md_we) begin
        if (bus.md_addr) m_hi <= bus.md_wdata;
        else m_lo <= bus.md_wdata;
      end
    end
  end

  // Reference: an md op issues once the cycle count has passed the previous op's ready cycle
  // and the MDU reports idle.
  int unsigned cyc_n = 1;
  int unsigned acc_cyc = 0;
  int unsigned ready_cyc = 0;
  bit          err_ref = 1'b0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, output logic got_stall, output logic [31:0] got_mf);
    logic req, es, acc, ewe, ead;
    logic [2:0] est;
    logic [31:0] emf;
    e_valid = v;
    md_op   = op;
    rs_val  = a;
    rt_val  = b;
    @(negedge clk);
    req = v && (op >= 4'd1) && (op <= 4'd8);
    es  = req && ((cyc_n < ready_cyc) || (bus.md_busy != 4'd0));
    acc = req && !es;
    est = 3'b000;
    ewe = 1'b0;
    ead = 1'b0;
    emf = 32'd0;
    if (acc) begin
      case (op)
        4'd1: est = 3'b010;
        4'd2: est = 3'b001;
        4'd3: est = 3'b100;
        4'd4: est = 3'b011;
        4'd5: begin ead = 1'b1; emf = ref_hi; end
        4'd6: emf = ref_lo;
        4'd7: begin ewe = 1'b1; ead = 1'b1; end
        4'd8: ewe = 1'b1;
        default: ;
      endcase
    end
    chk("stall", 32'(stall), 32'(es));
    chk("md_start", 32'(bus.md_start), 32'(est));
    chk("md_we", 32'(bus.md_we), 32'(ewe));
    chk("md_addr", 32'(bus.md_addr), 32'(ead));
    chk("mf_result", mf_result, emf);
    chk("proto_err", 32'(proto_err), 32'(err_ref));
    chk("md_in1", bus.md_in1, a);
    chk("md_in2", bus.md_in2, b);
    chk("md_wdata", bus.md_wdata, a);
    if (cyc_n > acc_cyc && cyc_n < ready_cyc && 32'(bus.md_busy) != ready_cyc - cyc_n)
      err_ref = 1'b1;
    if (acc) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        acc_cyc   = cyc_n;
        ready_cyc = cyc_n + ((op <= 4'd2) ? LatMul : LatDiv) + 1;
        md_calc(op, a, b, ref_hi, ref_lo);
      end else if (op == 4'd7) ref_hi = a;
      else if (op == 4'd8) ref_lo = a;
    end
    got_stall = stall;
    got_mf    = mf_result;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n_st, output logic [31:0] mf);
    logic s;
    n_st = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, op, a, b, s, mf);
      if (!s) return;
      n_st++;
    end
    chk("issue_timeout", 32'(n_st), 32'd0);
  endtask

  task automatic ref_reset();
    acc_cyc   = 0;
    ready_cyc = 0;
    err_ref   = 1'b0;
    ref_hi    = 32'd0;
    ref_lo    = 32'd0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_start"}, 32'(bus.md_start), 32'd0);
    chk({tag, "_we"}, 32'(bus.md_we), 32'd0);
    chk({tag, "_mf"}, mf_result, 32'd0);
    chk({tag, "_err"}, 32'(proto_err), 32'd0);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    e_valid = 1'b1;
    md_op   = 4'd1;
    #1;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    e_valid = 1'b0;
    reset   = 1'b1;
    ref_reset();
  endtask

  int          n_st;
  logic [31:0] mf;
  logic        s;

  initial begin
    do_reset();

    // mult then mfhi
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, n_st, mf);
    chk("mult_issue_stall", 32'(n_st), 32'd0);
    issue(4'd5, 32'd0, 32'd0, n_st, mf);
    chk("mfhi_after_mult_stall", 32'(n_st), 32'(LatMul));
    chk("mfhi_after_mult_val", mf, 32'hFFFF_FFFF);

    // divu then mflo, mfhi
    issue(4'd4, 32'd7, 32'd2, n_st, mf);
    issue(4'd6, 32'd0, 32'd0, n_st, mf);
    chk("mflo_after_divu_stall", 32'(n_st), 32'(LatDiv));
    chk("mflo_after_divu_val", mf, 32'd3);
    issue(4'd5, 32'd0, 32'd0, n_st, mf);
    chk("mfhi_after_divu_stall", 32'(n_st), 32'd0);
    chk("mfhi_after_divu_val", mf, 32'd1);

    // mthi during div
    issue(4'd3, 32'd100, 32'd7, n_st, mf);
    issue(4'd7, 32'h0000_1234, 32'd0, n_st, mf);
    chk("mthi_during_div_stall", 32'(n_st), 32'(LatDiv));
    issue(4'd5, 32'd0, 32'd0, n_st, mf);
    chk("mfhi_after_mthi_val", mf, 32'h0000_1234);

    // MDU misreports multiply busy as 6
    mdu_mul_busy = 6;
    issue(4'd1, 32'd3, 32'd4, n_st, mf);
    issue(4'd5, 32'd0, 32'd0, n_st, mf);
    chk("slow_mdu_stall", 32'(n_st), 32'd6);
    chk("slow_mdu_proto_err", 32'(proto_err), 32'd1);
    mdu_mul_busy = LatMul;
    do_reset();
    chk("proto_err_cleared", 32'(proto_err), 32'd0);

    // reset mid-div
    issue(4'd4, 32'd50, 32'd3, n_st, mf);
    repeat (3) cyc(1'b1, 4'd5, 32'd0, 32'd0, s, mf);
    e_valid = 1'b1;
    md_op   = 4'd1;
    reset   = 1'b0;
    #1;
    check_quiet("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    ref_reset();
    issue(4'd1, 32'd5, 32'd6, n_st, mf);
    chk("mult_after_reset_stall", 32'(n_st), 32'd0);
    issue(4'd6, 32'd0, 32'd0, n_st, mf);
    chk("mflo_after_reset_val", mf, 32'd30);

    // invalid / out-of-range ops
    cyc(1'b0, 4'd1, 32'd9, 32'd9, s, mf);
    chk("novalid_stall", 32'(s), 32'd0);
    cyc(1'b1, 4'd12, 32'd9, 32'd9, s, mf);
    chk("op12_stall", 32'(s), 32'd0);
    issue(4'd6, 32'd0, 32'd0, n_st, mf);
    chk("idle_after_noops", 32'(n_st), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  r_op;
      logic [31:0] r_a, r_b;
      logic        r_v;
      r_v  = ($urandom_range(0, 3) != 0);
      r_op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) r_op = 4'($urandom_range(1, 8));
      r_a = $urandom;
      r_b = (r_op == 4'd3 || r_op == 4'd4) ? 32'($urandom_range(1, 1000)) : $urandom;
      cyc(r_v, r_op, r_a, r_b, s, mf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
